alu32_ctrl: RTL and testbench

//  Command sequencer that owns one alu32 datapath. Buffers {op,a,b} commands in a small FIFO.

---
 rtl/alu32_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alu32_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_ctrl.sv
// alu32_ctrl: command sequencer around a 32-bit ALU.
// Buffers {op, a, b} commands in a 1<<AW entry FIFO, executes them one at a time and returns
// each registered result over a valid/ready port, strictly in command order.
// Optional feature macro: ALU_CTRL_CHAIN_EN (cmd_chain substitutes the last result for A).
module alu32_ctrl #(
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [31:0]   cmd_a,
  input  logic [31:0]   cmd_b,
  input  logic          cmd_chain,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_data,
  output logic          res_err,
  output logic          busy,
  output logic [AW:0]   cmd_count
);

  localparam int unsigned Depth    = 1 << AW;
  localparam logic [AW:0] DepthCnt = Depth[AW:0];

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  // FIFO storage and pointers
  logic [3:0]    op_mem_q [Depth];
  logic [31:0]   a_mem_q  [Depth];
  logic [31:0]   b_mem_q  [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  // Sequencer state and registered ALU operands/results
  state_e      state_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] res_q;
  logic        err_q;
  logic        valid_q;
  logic [31:0] last_q;

  logic        push, pop, hs;
  logic [31:0] head_a;
  logic [31:0] alu_res;
  logic        alu_err;

  assign push = cmd_valid & cmd_ready;
  assign hs   = (state_q == StResp) & res_ready;
  // Pop decision uses the registered count only, so a same-cycle push is never bypassed.
  assign pop  = (count_q != '0) & ((state_q == StIdle) | hs);

`ifdef ALU_CTRL_CHAIN_EN
  logic chain_mem_q [Depth];

  // Operand A source; forward the result being handshaken this cycle, as it is the newest.
  always_comb begin
    head_a = a_mem_q[rd_ptr_q];
    if (chain_mem_q[rd_ptr_q]) begin
      head_a = hs ? res_q : last_q;
    end
  end

  // Chain flag travels with its command
  always_ff @(posedge clk) begin
    if (push) begin
      chain_mem_q[wr_ptr_q] <= cmd_chain;
    end
  end
`else
  logic unused_chain;

  assign head_a       = a_mem_q[rd_ptr_q];
  assign unused_chain = cmd_chain ^ (^last_q);
`endif

  // FIFO payload storage; contents need no reset, validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q] <= cmd_op;
      a_mem_q[wr_ptr_q]  <= cmd_a;
      b_mem_q[wr_ptr_q]  <= cmd_b;
    end
  end

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ALU datapath; illegal opcodes are forced to zero with the error flag set
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (op_q)
      4'd0:    alu_res = '0;
      4'd1:    alu_res = ~a_q;
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = ~(a_q ^ b_q);
      4'd6:    alu_res = a_q + b_q;
      4'd7:    alu_res = a_q - b_q;
      default: alu_err = 1'b1;
    endcase
  end

  // Sequencer FSM with registered result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            op_q    <= op_mem_q[rd_ptr_q];
            a_q     <= head_a;
            b_q     <= b_mem_q[rd_ptr_q];
            state_q <= StExec;
          end
        end
        StExec: begin
          res_q   <= alu_res;
          err_q   <= alu_err;
          valid_q <= 1'b1;
          state_q <= StResp;
        end
        StResp: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            last_q  <= res_q;
            if (pop) begin
              op_q    <= op_mem_q[rd_ptr_q];
              a_q     <= head_a;
              b_q     <= b_mem_q[rd_ptr_q];
              state_q <= StExec;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (count_q != DepthCnt);
  assign busy      = (state_q != StIdle) | (count_q != '0);
  assign cmd_count = count_q;
  assign res_valid = valid_q;
  assign res_data  = {32'h0, res_q};
  assign res_err   = err_q;

endmodule

// File: tb/tb_alu32_ctrl.sv
// Scoreboard bench for alu32_ctrl: the driver pushes expected results from a reference model,
// a negedge monitor compares every presented result against the queue head.
module tb_alu32_ctrl;

`ifdef ALU_CTRL_CHAIN_EN
  localparam bit ChainEn = 1'b1;
`else
  localparam bit ChainEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        cmd_chain;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic        res_err, busy;
  logic [2:0]  cmd_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [64:0] exp_q [$];   // {err, data}
  logic [63:0] got_q [$];
  int          hs_cyc [$];
  logic [31:0] model_last;
  bit          rnd_done;

  alu32_ctrl #(.AW(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_chain (cmd_chain),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: opcode meaning taken straight from the opcode table, arithmetic mod 2^32
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned x, y, r;
    x = a;
    y = b;
    case (op)
      4'd0: r = 0;
      4'd1: r = 64'hFFFF_FFFF - x;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = 64'hFFFF_FFFF - (x ^ y);
      4'd6: r = (x + y) % 64'h1_0000_0000;
      4'd7: r = (x + 64'h1_0000_0000 - y) % 64'h1_0000_0000;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r[31:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ch);
    int n;
    logic [31:0] a_eff;
    logic [32:0] r;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = ch;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", {63'h0, cmd_ready}, 64'h1);
    if (cmd_ready) begin
      a_eff = (ChainEn && ch) ? model_last : a;
      r = ref_alu(op, a_eff, b);
      model_last = r[31:0];
      exp_q.push_back({r[32], 32'h0, r[31:0]});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", {63'h0, (exp_q.size() == 0) && !busy}, 64'h1);
  endtask

  // Monitor: compare every presented result (also while held) against the scoreboard head
  always @(negedge clk) begin
    if (reset_n && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", res_data, 64'hDEAD);
      end else begin
        chk("res_data", res_data, exp_q[0][63:0]);
        chk("res_err", {63'h0, res_err}, {63'h0, exp_q[0][64]});
        if (res_ready) begin
          void'(exp_q.pop_front());
          got_q.push_back(res_data);
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
    res_ready = 1'b1;
    model_last = '0;
    rnd_done = 1'b0;
    #1;
    chk("rst_res_valid", {63'h0, res_valid}, 64'h0);
    chk("rst_res_data", res_data, 64'h0);
    chk("rst_count", {61'h0, cmd_count}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD wrap-around, with latency check
    got_q.delete();
    send(4'd6, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk("lat_k", {63'h0, res_valid}, 64'h0);
    @(posedge clk); #1;
    chk("lat_k1", {63'h0, res_valid}, 64'h0);
    @(posedge clk); #1;
    chk("lat_k2", {63'h0, res_valid}, 64'h1);
    send(4'd7, 32'd3, 32'd5, 1'b0);
    drain();
    chk("add_wrap", got_q[0], 64'h0);
    chk("sub_neg", got_q[1], 64'h0000_0000_FFFF_FFFE);

    // Back-pressure: fill FIFO while one result is held
    got_q.delete();
    res_ready = 1'b0;
    send(4'd2, 32'hF0F0, 32'hFF00, 1'b0);
    send(4'd3, 32'hF0F0, 32'hFF00, 1'b0);
    send(4'd4, 32'hF0F0, 32'hFF00, 1'b0);
    send(4'd5, 32'hF0F0, 32'hFF00, 1'b0);
    send(4'd1, 32'hF0F0, $urandom, 1'b0);
    chk("bp_count", {61'h0, cmd_count}, 64'd4);
    chk("bp_ready", {63'h0, cmd_ready}, 64'h0);
    cmd_valid = 1'b1; cmd_op = 4'd6;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_count", {61'h0, cmd_count}, 64'd4);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    drain();
    chk("bp_n", got_q.size(), 64'd5);
    if (got_q.size() == 5) begin
      chk("bp_and", got_q[0], 64'hF000);
      chk("bp_or", got_q[1], 64'hFFF0);
      chk("bp_xor", got_q[2], 64'h0FF0);
      chk("bp_xnor", got_q[3], 64'hFFFF_F00F);
      chk("bp_not", got_q[4], 64'hFFFF_0F0F);
    end

    // Illegal and NOP
    send(4'hA, $urandom, $urandom, 1'b0);
    send(4'h0, $urandom, $urandom, 1'b0);
    send(4'hF, $urandom, $urandom, 1'b0);
    drain();

    // Throughput: one result per two cycles with res_ready high
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd6, $urandom, $urandom, 1'b0);
    hs_cyc.delete();
    res_ready = 1'b1;
    drain();
    chk("tp_n", hs_cyc.size(), 64'd4);
    for (int i = 1; i < hs_cyc.size(); i++) chk("tp_gap", hs_cyc[i] - hs_cyc[i-1], 64'd2);

    // Async reset mid-RESP with three commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd3, $urandom, $urandom, 1'b0);
    chk("pre_rst_count", {61'h0, cmd_count}, 64'd3);
    chk("pre_rst_valid", {63'h0, res_valid}, 64'h1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {63'h0, res_valid}, 64'h0);
    chk("arst_data", res_data, 64'h0);
    chk("arst_count", {61'h0, cmd_count}, 64'h0);
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_ready", {63'h0, cmd_ready}, 64'h1);
    exp_q.delete();
    model_last = '0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Chain: last result is zero after reset, then 5+7 chained forward
    got_q.delete();
    send(4'd6, 32'd99, 32'd4, 1'b1);
    send(4'd6, 32'd5, 32'd7, 1'b0);
    send(4'd6, 32'd0, 32'd3, 1'b1);
    send(4'd7, 32'd0, 32'd20, 1'b1);
    drain();
    chk("ch_n", got_q.size(), 64'd4);
    if (got_q.size() == 4) begin
      chk("ch_after_rst", got_q[0], ChainEn ? 64'd4 : 64'd103);
      chk("ch_base", got_q[1], 64'd12);
      chk("ch_add", got_q[2], ChainEn ? 64'd15 : 64'd3);
      chk("ch_sub", got_q[3], ChainEn ? 64'hFFFF_FFFB : 64'hFFFF_FFEC);
    end

    // Random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
